// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch push-button front end.
// Optional long-press detection is enabled with BUTTON_DEBOUNCER_LONG_PRESS_EN.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } debounce_state_t;

  localparam int unsigned DEF_DEBOUNCE_CYCLES = 10000;
  localparam int unsigned DEF_LONG_CYCLES     = 2000000;

  localparam int unsigned BTN_ONE   = 0;
  localparam int unsigned BTN_TEN   = 1;
  localparam int unsigned BTN_PAUSE = 2;
  localparam int unsigned BTN_CLEAR = 3;

endpackage

// File: rtl/debounce_channel.sv
// One button channel: 2-flop synchronizer, debounce FSM, registered level/pulse outputs.
// Long-press pulse logic exists only when BUTTON_DEBOUNCER_LONG_PRESS_EN is defined.
module debounce_channel
  import stopwatch_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned LONG_CYCLES     = DEF_LONG_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic i_btn,
  output logic o_level,
  output logic o_press,
  output logic o_release,
  output logic o_long
);

  localparam int unsigned       CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

  if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
    $error("debounce_channel: DEBOUNCE_CYCLES must be at least 2");
  end
  if (LONG_CYCLES <= DEBOUNCE_CYCLES) begin : g_bad_long
    $error("debounce_channel: LONG_CYCLES must exceed DEBOUNCE_CYCLES");
  end

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_btn;
      r_sync <= r_meta;
    end
  end

  debounce_state_t   r_state;
  debounce_state_t   w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // cnt never passes CNT_LAST, so the increment cannot wrap
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      IDLE: begin
        if (r_sync) begin
          w_state_nxt = PRESS_WAIT;
          w_cnt_nxt   = CNT_ONE;
        end else begin
          w_cnt_nxt   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!r_sync) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = HELD;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt   = r_cnt + CNT_ONE;
        end
      end
      HELD: begin
        if (!r_sync) begin
          w_state_nxt = RELEASE_WAIT;
          w_cnt_nxt   = CNT_ONE;
        end else begin
          w_cnt_nxt   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (r_sync) begin
          w_state_nxt = HELD;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt   = r_cnt + CNT_ONE;
        end
      end
    endcase
  end

  logic r_level;
  logic r_press;
  logic r_release;
  logic w_level_nxt;
  logic w_press_nxt;
  logic w_release_nxt;

  // Pulses come from comparing the state with the previous registered level,
  // which places them one cycle after the accepting transition.
  always_comb begin
    w_level_nxt   = (r_state == HELD) || (r_state == RELEASE_WAIT);
    w_press_nxt   = (r_state == HELD) && !r_level;
    w_release_nxt = (r_state == IDLE) && r_level;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_level   <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_level   <= w_level_nxt;
      r_press   <= w_press_nxt;
      r_release <= w_release_nxt;
    end
  end

  assign o_level   = r_level;
  assign o_press   = r_press;
  assign o_release = r_release;

`ifdef BUTTON_DEBOUNCER_LONG_PRESS_EN
  localparam int unsigned       HOLD_W   = $clog2(LONG_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_CYCLES);

  logic [HOLD_W-1:0] r_hold;
  logic              r_long_done;
  logic              r_long;
  logic              w_hold_clr;
  logic              w_long_nxt;

  // Fresh press or return to IDLE restarts the hold; RELEASE_WAIT merely pauses it.
  always_comb begin
    w_hold_clr = ((r_state == PRESS_WAIT) && (w_state_nxt == HELD)) ||
                 (w_state_nxt == IDLE);
    w_long_nxt = (r_hold == HOLD_MAX) && !r_long_done;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hold      <= '0;
      r_long_done <= 1'b0;
      r_long      <= 1'b0;
    end else begin
      r_long <= w_long_nxt;
      if (w_hold_clr) begin
        r_hold      <= '0;
        r_long_done <= 1'b0;
      end else begin
        if ((r_state == HELD) && (r_hold != HOLD_MAX)) begin
          r_hold <= r_hold + HOLD_W'(1);
        end
        if (r_hold == HOLD_MAX) begin
          r_long_done <= 1'b1;
        end
      end
    end
  end

  assign o_long = r_long;
`else
  assign o_long = 1'b0;
`endif

endmodule

// File: rtl/button_debouncer.sv
// Multi-channel push-button debouncer: one independent debounce_channel per button.
// Define BUTTON_DEBOUNCER_LONG_PRESS_EN to enable btn_long; otherwise it is tied low.
module button_debouncer
  import stopwatch_pkg::*;
#(
  parameter int unsigned NUM_BTN         = 4,
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned LONG_CYCLES     = DEF_LONG_CYCLES
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_BTN-1:0] btn_in,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_release,
  output logic [NUM_BTN-1:0] btn_long
);

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .LONG_CYCLES     (LONG_CYCLES)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .i_btn     (btn_in[g]),
      .o_level   (btn_level[g]),
      .o_press   (btn_press[g]),
      .o_release (btn_release[g]),
      .o_long    (btn_long[g])
    );
  end

endmodule
